// File: rtl/sobel_pkg.sv
// Shared widths, pixel codes and FSM states for the Sobel edge path.
package sobel_pkg;

    localparam int PX_W  = 15;
    localparam int INT_W = 8;
    localparam int MAG_W = 11;

    localparam logic [MAG_W-1:0] MAG_MAX    = 11'd2040;
    localparam logic [PX_W-1:0]  EDGE_PX    = 15'h7FFF;
    localparam logic [PX_W-1:0]  NO_EDGE_PX = 15'h0000;

    typedef enum logic [2:0] {
        ST_READ,
        ST_SHIFT,
        ST_CALC,
        ST_WAIT,
        ST_WRITE
    } state_t;

    function automatic logic [MAG_W-1:0] absMag(input logic signed [MAG_W-1:0] v);
        return v[MAG_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/sobel_core.sv
// Combinational Sobel kernel: eight neighbours of a 3x3 window -> |Gx|+|Gy|.
import sobel_pkg::*;

module sobel_core (
    input  logic [INT_W-1:0] tl_i,
    input  logic [INT_W-1:0] tc_i,
    input  logic [INT_W-1:0] tr_i,
    input  logic [INT_W-1:0] ml_i,
    input  logic [INT_W-1:0] mr_i,
    input  logic [INT_W-1:0] bl_i,
    input  logic [INT_W-1:0] bc_i,
    input  logic [INT_W-1:0] br_i,
    output logic [MAG_W-1:0] mag_o
);

    logic signed [MAG_W-1:0] gx;
    logic signed [MAG_W-1:0] gy;

    function automatic logic signed [MAG_W-1:0] ext(input logic [INT_W-1:0] p);
        return signed'({{(MAG_W-INT_W){1'b0}}, p});
    endfunction

    // Worst case |G| per axis is 4*255 = 1020, so 11 signed bits never overflow.
    always_comb begin
        gx = (ext(tr_i) + (ext(mr_i) <<< 1) + ext(br_i))
           - (ext(tl_i) + (ext(ml_i) <<< 1) + ext(bl_i));
        gy = (ext(bl_i) + (ext(bc_i) <<< 1) + ext(br_i))
           - (ext(tl_i) + (ext(tc_i) <<< 1) + ext(tr_i));
        mag_o = absMag(gx) + absMag(gy);
    end

endmodule

// File: rtl/sobel_control.sv
// Streaming Sobel edge detector: one pixel per slot, 3x3 window over two line
// buffers, runtime threshold stepped by synchronised up/down buttons.
import sobel_pkg::*;

module sobel_control #(
    parameter int               WIDTH       = 320,
    parameter int               HEIGHT      = 240,
    parameter int               SLOT_CYCLES = 10,
    parameter logic [MAG_W-1:0] THRESH_INIT = 11'd256,
    parameter logic [MAG_W-1:0] THRESH_STEP = 11'd32
) (
    input  logic            sobel_clk,
    input  logic            reset,
    input  logic            threshold_up,
    input  logic            threshold_down,
    input  logic            ack_read,
    input  logic [PX_W-1:0] input_px_gray,
    input  logic            ack_write,
    output logic [PX_W-1:0] output_px_sobel
);

    localparam int COL_W      = $clog2(WIDTH);
    localparam int ROW_W      = $clog2(HEIGHT);
    localparam int PAD_CYCLES = SLOT_CYCLES - 4;
    localparam int PAD_W      = $clog2(PAD_CYCLES);

    state_t            state_q;
    logic [PAD_W-1:0]  pad_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [INT_W-1:0]  pixel_q;
    logic              border_q;
    logic              edge_q;

    logic [INT_W-1:0]  win_q [3][3];
    logic [INT_W-1:0]  lineA_q [WIDTH];
    logic [INT_W-1:0]  lineB_q [WIDTH];

    logic [1:0]        upSync_q;
    logic [1:0]        downSync_q;
    logic              upPrev_q;
    logic              downPrev_q;
    logic [MAG_W-1:0]  thresh_q;
    logic [MAG_W-1:0]  thresh_d;
    logic [MAG_W:0]    threshSum;
    logic              upRise;
    logic              downRise;
    logic [MAG_W-1:0]  mag;
    logic              unusedBits;

    assign unusedBits = ^input_px_gray[PX_W-1:INT_W];

    assign upRise    = upSync_q[1] & ~upPrev_q;
    assign downRise  = downSync_q[1] & ~downPrev_q;
    assign threshSum = {1'b0, thresh_q} + {1'b0, THRESH_STEP};

    // Simultaneous up and down presses cancel out.
    always_comb begin
        thresh_d = thresh_q;
        if (upRise && !downRise) begin
            thresh_d = (threshSum > {1'b0, MAG_MAX}) ? MAG_MAX : threshSum[MAG_W-1:0];
        end else if (downRise && !upRise) begin
            thresh_d = (thresh_q < THRESH_STEP) ? '0 : thresh_q - THRESH_STEP;
        end
    end

    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            upSync_q   <= '0;
            downSync_q <= '0;
            upPrev_q   <= 1'b0;
            downPrev_q <= 1'b0;
            thresh_q   <= THRESH_INIT;
        end else begin
            upSync_q   <= {upSync_q[0], threshold_up};
            downSync_q <= {downSync_q[0], threshold_down};
            upPrev_q   <= upSync_q[1];
            downPrev_q <= downSync_q[1];
            thresh_q   <= thresh_d;
        end
    end

    // Right window column takes the pixels two rows up, one row up and the new one.
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                lineA_q[i] <= '0;
                lineB_q[i] <= '0;
            end
        end else if (state_q == ST_SHIFT) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2]    <= lineB_q[col_q];
            win_q[1][2]    <= lineA_q[col_q];
            win_q[2][2]    <= pixel_q;
            lineB_q[col_q] <= lineA_q[col_q];
            lineA_q[col_q] <= pixel_q;
        end
    end

    sobel_core u_core (
        .tl_i  (win_q[0][0]),
        .tc_i  (win_q[0][1]),
        .tr_i  (win_q[0][2]),
        .ml_i  (win_q[1][0]),
        .mr_i  (win_q[1][2]),
        .bl_i  (win_q[2][0]),
        .bc_i  (win_q[2][1]),
        .br_i  (win_q[2][2]),
        .mag_o (mag)
    );

    // The center trails the new pixel by one row and one column, so it sits on
    // the frame border exactly when the new pixel is in row 0/1 or column 0/1.
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_READ;
            pad_q           <= '0;
            col_q           <= '0;
            row_q           <= '0;
            pixel_q         <= '0;
            border_q        <= 1'b1;
            edge_q          <= 1'b0;
            output_px_sobel <= NO_EDGE_PX;
        end else begin
            case (state_q)
                ST_READ: begin
                    if (ack_read) begin
                        pixel_q <= input_px_gray[INT_W-1:0];
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    border_q <= (row_q <= ROW_W'(1)) || (col_q <= COL_W'(1));
                    if (col_q == COL_W'(WIDTH - 1)) begin
                        col_q <= '0;
                        row_q <= (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    edge_q  <= !border_q && (mag > thresh_q);
                    pad_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pad_q == PAD_W'(PAD_CYCLES - 1)) begin
                        state_q <= ST_WRITE;
                    end else begin
                        pad_q <= pad_q + PAD_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (ack_write) begin
                        output_px_sobel <= edge_q ? EDGE_PX : NO_EDGE_PX;
                        state_q         <= ST_READ;
                    end
                end
                default: state_q <= ST_READ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_control.sv
// Directed/random bench for sobel_control on a reduced 8x6 frame, checked
// against a neighbourhood-arithmetic model of the edge stream.
`timescale 1ns/1ps

module tb_sobel_control;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int SLOT = 10;
    localparam logic [14:0] EDGE    = 15'h7FFF;
    localparam logic [14:0] NO_EDGE = 15'h0000;

    logic        clk = 1'b0;
    logic        rstN;
    logic        thresholdUp;
    logic        thresholdDown;
    logic        ackRead;
    logic        ackWrite;
    logic [14:0] pxIn;
    logic [14:0] output_px_sobel;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          hist[$];
    int          modelThr;
    int          dutEdges;
    logic [14:0] lastExp;

    always #20 clk = ~clk;

    sobel_control #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .sobel_clk       (clk),
        .reset           (rstN),
        .threshold_up    (thresholdUp),
        .threshold_down  (thresholdDown),
        .ack_read        (ackRead),
        .input_px_gray   (pxIn),
        .ack_write       (ackWrite),
        .output_px_sobel (output_px_sobel)
    );

    // Output n reports center n-(W+1) of the pixel stream since reset.
    function automatic logic [14:0] modelOut(input int n);
        int c, pos, r, col, gx, gy, mag;
        if (n < W + 1) return NO_EDGE;
        c   = n - W - 1;
        pos = c % (W * H);
        r   = pos / W;
        col = pos % W;
        if (r == 0 || r == H - 1 || col == 0 || col == W - 1) return NO_EDGE;
        gx = (hist[c-W+1] + 2 * hist[c+1] + hist[c+W+1])
           - (hist[c-W-1] + 2 * hist[c-1] + hist[c+W-1]);
        gy = (hist[c+W-1] + 2 * hist[c+W] + hist[c+W+1])
           - (hist[c-W-1] + 2 * hist[c-W] + hist[c-W+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > modelThr) ? EDGE : NO_EDGE;
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] expv);
        checks++;
        assert (output_px_sobel === expv) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, output_px_sobel, expv);
        end
    endtask

    task automatic checkCount(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic applyStimulus(input int px, input int readStall, input int writeStall);
        logic [14:0] expv;
        if (readStall > 0) begin
            ackRead = 1'b0;
            pxIn    = 15'($urandom);
            repeat (readStall) @(posedge clk);
            #1 checkOutput("read_stall_hold", lastExp);
        end
        pxIn    = {7'($urandom), 8'(px)};
        ackRead = 1'b1;
        repeat (SLOT - 1) @(posedge clk);
        #1 checkOutput("pre_write", lastExp);
        if (writeStall > 0) begin
            ackWrite = 1'b0;
            pxIn     = 15'($urandom);
            repeat (writeStall) @(posedge clk);
            #1 checkOutput("write_stall_hold", lastExp);
            ackWrite = 1'b1;
        end
        @(posedge clk);
        #1;
        hist.push_back(px);
        expv = modelOut(hist.size() - 1);
        checkOutput("pixel", expv);
        if (output_px_sobel === EDGE) dutEdges++;
        lastExp = expv;
    endtask

    function automatic int genPixel(input int kind, input int idx);
        case (kind)
            0:       return 8'h80;
            1:       return ((idx % W) < W / 2) ? 0 : 255;
            2:       return $urandom_range(0, 63);
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    task automatic runFrame(input int kind, input int count, input int stallEvery);
        for (int i = 0; i < count; i++) begin
            applyStimulus(genPixel(kind, i),
                          (stallEvery > 0 && i % stallEvery == 3) ? 7 : 0,
                          (stallEvery > 0 && i % stallEvery == 0) ? 50 : 0);
        end
    endtask

    task automatic pulseThreshold(input bit up, input bit down, input int times);
        ackRead = 1'b0;
        repeat (times) begin
            thresholdUp   = up;
            thresholdDown = down;
            repeat (3) @(posedge clk);
            #1;
            thresholdUp   = 1'b0;
            thresholdDown = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            if (up && !down)      modelThr = (modelThr + 32 > 2040) ? 2040 : modelThr + 32;
            else if (down && !up) modelThr = (modelThr < 32) ? 0 : modelThr - 32;
        end
    endtask

    initial begin
        rstN          = 1'b0;
        thresholdUp   = 1'b0;
        thresholdDown = 1'b0;
        ackRead       = 1'b0;
        ackWrite      = 1'b1;
        pxIn          = '0;
        modelThr      = 256;
        lastExp       = NO_EDGE;
        #50 checkOutput("reset_output", NO_EDGE);
        @(negedge clk) rstN = 1'b1;

        runFrame(0, W * H, 0);
        dutEdges = 0;
        runFrame(1, W * H, 0);
        checkCount("step_edges_256", dutEdges, 8);

        pulseThreshold(1'b1, 1'b0, 10);
        checkCount("thresh_after_10_up", modelThr, 576);
        dutEdges = 0;
        runFrame(1, W * H, 0);
        checkCount("step_edges_576", dutEdges, 8);

        pulseThreshold(1'b1, 1'b0, 80);
        dutEdges = 0;
        runFrame(1, W * H, 0);
        checkCount("step_edges_sat", dutEdges, 0);

        pulseThreshold(1'b0, 1'b1, 80);
        dutEdges = 0;
        runFrame(0, W * H, 0);
        checkCount("flat_edges_zero_thr", dutEdges, 0);
        runFrame(3, W * H, 5);

        pulseThreshold(1'b1, 1'b0, 8);
        pulseThreshold(1'b1, 1'b1, 2);
        runFrame(2, W * H, 0);

        pulseThreshold(1'b1, 1'b0, 4);
        runFrame(2, W * H, 6);

        for (int i = 0; i < W * H && lastExp !== EDGE; i++) begin
            applyStimulus(genPixel(1, i), 0, 0);
        end
        checkOutput("edge_before_reset", EDGE);
        ackRead = 1'b1;
        pxIn    = 15'h00FF;
        repeat (4) @(posedge clk);
        #1 rstN = 1'b0;
        #1 checkOutput("reset_mid_slot", NO_EDGE);
        hist.delete();
        modelThr = 256;
        lastExp  = NO_EDGE;
        ackRead  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        runFrame(2, W * H, 0);
        dutEdges = 0;
        runFrame(1, W * H, 0);
        checkCount("step_edges_after_reset", dutEdges, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
